adc_frame_sender: RTL and testbench

Downstream consumer of the channel-0 capture stage. Once a capture completes, it drains the capture FIFO and serialises each 10-bit sample into a framed byte stream, using a valid/ready handshake toward the UART/SPI transmitter. When the FIFO is empty it pulses `ADC0_bg` to re-arm the capture for the next acquisition.

---
 rtl/adc_frame_sender.sv | 175 +++++++++++++++++
 tb/tb_adc_frame_sender.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_sender.sv
// Drains the channel-0 capture FIFO into a framed byte stream (A5 5A id, samples,
// count, checksum) over a valid/ready link, then pulses ADC0_bg to re-arm capture.
module adc_frame_sender #(
    parameter logic [7:0] CH_ID       = 8'h00,
    parameter int         MAX_SAMPLES = 4096
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ADC0_end,
    input  logic       empty,
    input  logic [9:0] ADC0_F_O_Data,
    input  logic       send_en,
    input  logic       tx_ready,
    output logic       rdreq,
    output logic       ADC0_bg,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, HDR, RD, LAT, SND_H, SND_L, CNT, CKS, DRAIN, REARM
    } state_t;

    localparam logic [12:0] MAX_CNT = 13'(MAX_SAMPLES);

    state_t      state;
    logic [1:0]  hdr_idx;
    logic        cnt_lo;
    logic        tail_done;
    logic [12:0] cnt;
    logic [7:0]  cks;
    logic [7:0]  sample_lo;
    logic        xfer;
    logic [7:0]  cks_next;
    logic [15:0] count_word;

    assign xfer       = tx_valid && tx_ready;
    assign cks_next   = cks + tx_data;
    assign count_word = {3'b000, cnt};

    // rdreq follows the live empty flag so a read is never issued on an empty FIFO
    always_comb begin
        rdreq = 1'b0;
        case (state)
            RD:      rdreq = !empty && (cnt != MAX_CNT);
            DRAIN:   rdreq = !empty;
            default: rdreq = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            hdr_idx   <= 2'd0;
            cnt_lo    <= 1'b0;
            tail_done <= 1'b0;
            cnt       <= 13'd0;
            cks       <= 8'h00;
            sample_lo <= 8'h00;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            ADC0_bg   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ADC0_bg <= 1'b0;
            case (state)
                IDLE: begin
                    if (ADC0_end && send_en) begin
                        state     <= HDR;
                        hdr_idx   <= 2'd0;
                        cnt       <= 13'd0;
                        cks       <= 8'h00;
                        tail_done <= 1'b0;
                        tx_data   <= 8'hA5;
                        tx_valid  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                HDR: begin
                    if (xfer) begin
                        hdr_idx <= hdr_idx + 2'd1;
                        case (hdr_idx)
                            2'd0:    tx_data <= 8'h5A;
                            2'd1:    tx_data <= CH_ID;
                            default: begin
                                cks      <= cks_next;
                                tx_valid <= 1'b0;
                                state    <= RD;
                            end
                        endcase
                    end
                end
                RD: begin
                    if (empty) begin
                        state    <= CNT;
                        cnt_lo   <= 1'b0;
                        tx_data  <= count_word[15:8];
                        tx_valid <= 1'b1;
                    end else if (cnt == MAX_CNT) begin
                        state <= DRAIN;
                    end else begin
                        state <= LAT;
                    end
                end
                LAT: begin
                    // high byte goes out straight from the FIFO word; low byte is held
                    sample_lo <= ADC0_F_O_Data[7:0];
                    tx_data   <= {6'b000000, ADC0_F_O_Data[9:8]};
                    tx_valid  <= 1'b1;
                    state     <= SND_H;
                end
                SND_H: begin
                    if (xfer) begin
                        cks     <= cks_next;
                        tx_data <= sample_lo;
                        state   <= SND_L;
                    end
                end
                SND_L: begin
                    if (xfer) begin
                        cks      <= cks_next;
                        cnt      <= cnt + 13'd1;
                        tx_valid <= 1'b0;
                        state    <= RD;
                    end
                end
                CNT: begin
                    if (xfer) begin
                        cks <= cks_next;
                        if (!cnt_lo) begin
                            cnt_lo  <= 1'b1;
                            tx_data <= count_word[7:0];
                        end else begin
                            tx_data <= cks_next;
                            state   <= CKS;
                        end
                    end
                end
                CKS: begin
                    if (xfer) begin
                        tx_valid  <= 1'b0;
                        tail_done <= 1'b1;
                        if (empty) begin
                            ADC0_bg <= 1'b1;
                            state   <= REARM;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // an overflowing frame drains first and sends its trailer afterwards
                    if (empty) begin
                        if (tail_done) begin
                            ADC0_bg <= 1'b1;
                            state   <= REARM;
                        end else begin
                            state    <= CNT;
                            cnt_lo   <= 1'b0;
                            tx_data  <= count_word[15:8];
                            tx_valid <= 1'b1;
                        end
                    end
                end
                REARM: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_sender.sv
// Bench for adc_frame_sender: FIFO and byte-sink models, frame reference model
// built from the frame-format rules, directed plus randomized frames.
module tb_adc_frame_sender;

    localparam logic [7:0] CH   = 8'h00;
    localparam int         MAXS = 4;

    logic       Clk = 1'b0;
    logic       Reset_n, ADC0_end, empty, send_en, tx_ready;
    logic [9:0] ADC0_F_O_Data;
    logic       rdreq, ADC0_bg, tx_valid, busy;
    logic [7:0] tx_data;

    adc_frame_sender #(.CH_ID(CH), .MAX_SAMPLES(MAXS)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .ADC0_end(ADC0_end), .empty(empty),
        .ADC0_F_O_Data(ADC0_F_O_Data), .send_en(send_en), .tx_ready(tx_ready),
        .rdreq(rdreq), .ADC0_bg(ADC0_bg), .tx_data(tx_data), .tx_valid(tx_valid),
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    int         passed = 0, total = 0;
    logic [9:0] fifo_q[$];
    logic [9:0] smp[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         n_words, bg_cnt, rdreq_cnt, rd_empty_viol, stall_viol, bg_early;
    bit         rand_ready = 1'b0;
    bit         pend_v = 1'b0, prev_stall = 1'b0;
    logic [7:0] pend_d, prev_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // FIFO model: normal mode, word appears the cycle after the read strobe
    always @(posedge Clk) begin
        bit r;
        r = rdreq;
        if (r) begin
            rdreq_cnt++;
            if (empty) rd_empty_viol++;
        end
        #1;
        if (r && Reset_n && fifo_q.size() > 0) begin
            ADC0_F_O_Data = fifo_q.pop_front();
            empty = (fifo_q.size() == 0);
        end
    end

    // byte sink: picks tx_ready, predicts the transfer at the next edge, checks stalls
    always @(negedge Clk) begin
        if (!Reset_n) prev_stall = 1'b0;
        else if (prev_stall && !(tx_valid && tx_data == prev_d)) stall_viol++;
        tx_ready   = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        pend_v     = Reset_n && tx_valid && tx_ready;
        pend_d     = tx_data;
        prev_stall = Reset_n && tx_valid && !tx_ready;
        prev_d     = tx_data;
        if (ADC0_bg) begin
            bg_cnt++;
            if (!empty) bg_early++;
        end
    end

    always @(posedge Clk) if (pend_v && Reset_n) got_q.push_back(pend_d);

    // reference frame: header, first min(n, MAXS) samples, 16-bit count, sum after 0x5A
    function automatic void build_exp();
        int         n;
        logic [9:0] w;
        logic [7:0] sum;
        n = (smp.size() < MAXS) ? smp.size() : MAXS;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(CH);
        for (int i = 0; i < n; i++) begin
            w = smp[i];
            exp_q.push_back({6'b000000, w[9:8]});
            exp_q.push_back(w[7:0]);
        end
        exp_q.push_back(8'(n >> 8));
        exp_q.push_back(8'(n));
        sum = 8'h00;
        for (int i = 2; i < exp_q.size(); i++) sum = sum + exp_q[i];
        exp_q.push_back(sum);
    endfunction

    task automatic load();
        fifo_q = smp;
        n_words = smp.size();
        empty = (smp.size() == 0);
        build_exp();
        got_q.delete();
        bg_cnt = 0; rdreq_cnt = 0; rd_empty_viol = 0; stall_viol = 0; bg_early = 0;
    endtask

    task automatic rand_samples(input int n);
        smp.delete();
        for (int i = 0; i < n; i++) smp.push_back(10'($urandom));
    endtask

    task automatic pulse_end(input string tag);
        ADC0_end = 1'b1;
        @(negedge Clk);
        ADC0_end = 1'b0;
        chk({tag, " first valid"}, 32'(tx_valid), 32'd1);
        chk({tag, " first byte"}, 32'(tx_data), 32'hA5);
    endtask

    task automatic finish_frame(input string tag);
        int t;
        t = 0;
        while (bg_cnt == 0 && t < 3000) begin
            @(negedge Clk);
            t++;
        end
        chk({tag, " done"}, 32'(t < 3000), 32'd1);
        repeat (4) @(negedge Clk);
        chk({tag, " nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, " bg pulses"}, 32'(bg_cnt), 32'd1);
        chk({tag, " bg early"}, 32'(bg_early), 32'd0);
        chk({tag, " busy low"}, 32'(busy), 32'd0);
        chk({tag, " reads"}, 32'(rdreq_cnt), 32'(n_words));
        chk({tag, " rd on empty"}, 32'(rd_empty_viol), 32'd0);
        chk({tag, " stall stable"}, 32'(stall_viol), 32'd0);
    endtask

    initial begin
        int t;
        Reset_n = 1'b0; ADC0_end = 1'b0; send_en = 1'b1; empty = 1'b1;
        ADC0_F_O_Data = 10'h000; tx_ready = 1'b1;
        repeat (2) @(negedge Clk);
        chk("rst tx_valid", 32'(tx_valid), 32'd0);
        chk("rst tx_data", 32'(tx_data), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst rdreq", 32'(rdreq), 32'd0);
        chk("rst bg", 32'(ADC0_bg), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // three known samples, sink always ready
        smp.delete();
        smp.push_back(10'h3FF); smp.push_back(10'h155); smp.push_back(10'h002);
        load(); pulse_end("t3"); finish_frame("t3");

        // same samples, sink stalling at random
        rand_ready = 1'b1;
        load(); pulse_end("t3r"); finish_frame("t3r");
        rand_ready = 1'b0;

        // empty FIFO
        smp.delete();
        load(); pulse_end("t0"); finish_frame("t0");

        // six words against a four-sample limit
        rand_samples(6);
        load(); pulse_end("tmax"); finish_frame("tmax");

        // reset while the second sample's low byte is on the link
        rand_samples(4);
        load(); pulse_end("trst");
        t = 0;
        while (!(got_q.size() == 6 && tx_valid) && t < 200) begin
            @(negedge Clk);
            t++;
        end
        chk("trst reach", 32'(t < 200), 32'd1);
        #2 Reset_n = 1'b0;
        #1;
        chk("trst tx_valid", 32'(tx_valid), 32'd0);
        chk("trst rdreq", 32'(rdreq), 32'd0);
        chk("trst busy", 32'(busy), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        chk("trst no more bytes", 32'(got_q.size()), 32'd6);
        @(negedge Clk);
        rand_samples(3);
        load(); pulse_end("trst2"); finish_frame("trst2");

        // capture done but sending disabled
        rand_samples(2);
        load();
        send_en = 1'b0;
        ADC0_end = 1'b1;
        repeat (100) @(negedge Clk);
        chk("sen idle bytes", 32'(got_q.size()), 32'd0);
        chk("sen idle valid", 32'(tx_valid), 32'd0);
        chk("sen idle busy", 32'(busy), 32'd0);
        chk("sen idle reads", 32'(rdreq_cnt), 32'd0);
        send_en = 1'b1;
        @(negedge Clk);
        ADC0_end = 1'b0;
        chk("sen first valid", 32'(tx_valid), 32'd1);
        chk("sen first byte", 32'(tx_data), 32'hA5);
        finish_frame("sen");

        // randomized frames, including empty and overflowing ones
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            rand_samples($urandom_range(0, 7));
            load();
            pulse_end($sformatf("rnd%0d", f));
            finish_frame($sformatf("rnd%0d", f));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
